// File: rtl/issue_queue.sv
// issue_queue -- bundle FIFO between the dual-issue scheduler and decode/issue.
//
// Each entry holds a 128-bit bundle {instr_b, pc_b, instr_a, pc_a} plus a
// dual flag marking slot b as valid. The oldest bundle is presented with
// first-word fall-through on a valid/ready handshake.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   instr1, instr2    scheduler bundles (only instr2[63:0] is used)
//   write1            push instr1 as one bundle (dual if instr_b != 0)
//   write2            push instr1[63:0] then instr2[63:0] as two bundles
//   flush             discard all contents (wins over push/pop)
//   issue_ready       downstream accepts the head bundle
//   issue_valid/data/dual  head bundle and its slot-b flag (0 when empty)
//   fetch_stall       fewer than two free entries
//   overflow_err      sticky, a push was refused for lack of space
//
// Optional feature: define ISSUE_QUEUE_BYPASS_EN for a zero-latency bypass
// of the first incoming bundle when the queue is empty.
module issue_queue #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] instr1,
  input  logic [127:0] instr2,
  input  logic         write1,
  input  logic         write2,
  input  logic         flush,
  input  logic         issue_ready,
  output logic         issue_valid,
  output logic [127:0] issue_data,
  output logic         issue_dual,
  output logic         fetch_stall,
  output logic         overflow_err
);
  localparam int PW = AW + 1;

  logic [128:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          ovf_q, ovf_d;
  logic [PW-1:0] count;
  logic          q_valid;
  logic          pop;
  logic [1:0]    pushes;
  logic [PW:0]   free_after_pop;
  logic          space_ok;
  logic [128:0]  bun_a, bun_b, wr_data_a;
  logic          wr_en_a, wr_en_b;
  logic [AW-1:0] wr_idx_a, wr_idx_b, rd_idx;
  logic          byp_act, byp_take;
  logic          unused_instr2_hi;

  assign unused_instr2_hi = ^instr2[127:64];

  assign count   = wr_ptr_q - rd_ptr_q;
  assign q_valid = (count != '0);
  assign pop     = q_valid & issue_ready;
  assign pushes  = write2 ? 2'd2 : (write1 ? 2'd1 : 2'd0);
  assign rd_idx  = rd_ptr_q[AW-1:0];
  assign wr_idx_a = wr_ptr_q[AW-1:0];
  assign wr_idx_b = wr_idx_a + 1'b1;  // wraps to index 0 naturally

  // Space is judged after this cycle's pop so a full queue can push while popping.
  assign free_after_pop = (PW+1)'(DEPTH) - {1'b0, count} + (PW+1)'(pop);
  assign space_ok       = (free_after_pop >= (PW+1)'(pushes));

  // First incoming bundle; a write1 with empty slot b stores its upper half as zero.
  always_comb begin
    if (write2)                  bun_a = {1'b0, 64'd0, instr1[63:0]};
    else if (|instr1[127:96])    bun_a = {1'b1, instr1};
    else                         bun_a = {1'b0, 64'd0, instr1[63:0]};
  end
  assign bun_b = {1'b0, 64'd0, instr2[63:0]};

`ifdef ISSUE_QUEUE_BYPASS_EN
  assign byp_act  = !q_valid && !flush && (pushes != 2'd0);
  assign byp_take = byp_act && issue_ready;
`else
  assign byp_act  = 1'b0;
  assign byp_take = 1'b0;
`endif

  always_comb begin
    wr_en_a   = 1'b0;
    wr_en_b   = 1'b0;
    wr_data_a = bun_a;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q + PW'(pop);
    ovf_d     = ovf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else if (pushes != 2'd0) begin
      if (!space_ok) begin
        ovf_d = 1'b1;
      end else if (byp_take) begin
        // First bundle went straight out; only a write2 tail needs storing.
        if (write2) begin
          wr_en_a   = 1'b1;
          wr_data_a = bun_b;
          wr_ptr_d  = wr_ptr_q + PW'(1);
        end
      end else begin
        wr_en_a  = 1'b1;
        wr_en_b  = write2;
        wr_ptr_d = wr_ptr_q + PW'(pushes);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en_a) mem_q[wr_idx_a] <= wr_data_a;
    if (wr_en_b) mem_q[wr_idx_b] <= bun_b;
  end

  always_comb begin
    issue_valid = q_valid | byp_act;
    issue_data  = '0;
    issue_dual  = 1'b0;
    if (byp_act) begin
      issue_data = bun_a[127:0];
      issue_dual = bun_a[128];
    end else if (q_valid) begin
      issue_data = mem_q[rd_idx][127:0];
      issue_dual = mem_q[rd_idx][128];
    end
  end

  assign fetch_stall  = (PW'(DEPTH) - count) < PW'(2);
  assign overflow_err = ovf_q;

endmodule

// File: tb/tb_issue_queue.sv
module tb_issue_queue;
  logic         clk;
  logic         rst_n;
  logic [127:0] instr1, instr2;
  logic         write1, write2, flush, issue_ready;
  logic         issue_valid, issue_dual, fetch_stall, overflow_err;
  logic [127:0] issue_data;

  int n_chk = 0;
  int n_err = 0;

  issue_queue #(.DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr1(instr1), .instr2(instr2),
    .write1(write1), .write2(write2), .flush(flush),
    .issue_ready(issue_ready),
    .issue_valid(issue_valid), .issue_data(issue_data), .issue_dual(issue_dual),
    .fetch_stall(fetch_stall), .overflow_err(overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [128:0] obs, input logic [128:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [128:0] mq[$];
  logic [128:0] exp_b;
  int           n_pop;

  initial begin
    rst_n = 1'b0; instr1 = '0; instr2 = '0;
    write1 = 1'b0; write2 = 1'b0; flush = 1'b0; issue_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_valid", issue_valid, 0);
    chk("rst_data", issue_data, 0);
    chk("rst_dual", issue_dual, 0);
    chk("rst_stall", fetch_stall, 0);
    chk("rst_ovf", overflow_err, 0);

    // dual push
    instr1 = {32'h00208033, 32'h104, 32'h00100093, 32'h100};
    write1 = 1'b1;
    tick();
    write1 = 1'b0;
    chk("dual_valid", issue_valid, 1);
    chk("dual_flag", issue_dual, 1);
    chk("dual_data", issue_data, {32'h00208033, 32'h104, 32'h00100093, 32'h100});
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    chk("dual_empty_valid", issue_valid, 0);
    chk("dual_empty_data", issue_data, 0);

    // write1 with instr_b == 0: single, upper half zeroed
    instr1 = {32'h0, 32'h5555, 32'h00300113, 32'h180};
    write1 = 1'b1;
    tick();
    write1 = 1'b0;
    chk("single_dual", issue_dual, 0);
    chk("single_data", issue_data, {64'd0, 32'h00300113, 32'h180});
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;

    // split push, garbage in ignored upper halves
    instr1 = {32'hDEADBEEF, 32'hCAFE, 32'h0000A103, 32'h200};
    instr2 = {32'h12345678, 32'h9ABC, 32'h0020A023, 32'h204};
    write2 = 1'b1;
    tick();
    write2 = 1'b0;
    chk("split1_valid", issue_valid, 1);
    chk("split1_dual", issue_dual, 0);
    chk("split1_data", issue_data, {64'd0, 32'h0000A103, 32'h200});
    issue_ready = 1'b1;
    tick();
    chk("split2_dual", issue_dual, 0);
    chk("split2_data", issue_data, {64'd0, 32'h0020A023, 32'h204});
    tick();
    issue_ready = 1'b0;
    chk("split_empty", issue_valid, 0);

    // full / overflow
    for (int i = 0; i < 7; i++) begin
      instr1 = {64'd0, 32'h11110000 + 32'(i), 32'h300 + 32'(4 * i)};
      write1 = 1'b1;
      tick();
    end
    write1 = 1'b0;
    chk("full7_stall", fetch_stall, 1);
    chk("full7_ovf", overflow_err, 0);
    instr1 = {64'd0, 32'h22220000, 32'h400};
    instr2 = {64'd0, 32'h22220001, 32'h404};
    write2 = 1'b1;
    tick();
    write2 = 1'b0;
    chk("w2_drop_ovf", overflow_err, 1);
    chk("w2_drop_head", issue_data, {64'd0, 32'h11110000, 32'h300});
    instr1 = {64'd0, 32'h11110007, 32'h31C};
    write1 = 1'b1;
    tick();
    chk("full8_stall", fetch_stall, 1);
    // push into a full queue while popping
    instr1 = {64'd0, 32'h11110008, 32'h320};
    issue_ready = 1'b1;
    tick();
    write1 = 1'b0;
    for (int j = 0; j < 8; j++) begin
      chk("drain_valid", issue_valid, 1);
      chk("drain_data", issue_data, {64'd0, 32'h11110000 + 32'(j + 1), 32'h300 + 32'(4 * (j + 1))});
      tick();
    end
    issue_ready = 1'b0;
    chk("drain_empty", issue_valid, 0);

    // reset mid-stream with 3 entries queued
    for (int i = 0; i < 3; i++) begin
      instr1 = {32'h1, 32'h8, 32'h33330000 + 32'(i), 32'h500 + 32'(8 * i)};
      write1 = 1'b1;
      tick();
    end
    write1 = 1'b0;
    chk("pre_rst_valid", issue_valid, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", issue_valid, 0);
    chk("async_rst_data", issue_data, 0);
    chk("async_rst_dual", issue_dual, 0);
    chk("async_rst_stall", fetch_stall, 0);
    chk("async_rst_ovf", overflow_err, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_valid", issue_valid, 0);

    // wrap with concurrency: 20 pushes (alternating write1/write2), ready held high
    issue_ready = 1'b1;
    n_pop = 0;
    for (int c = 0; c < 60; c++) begin
      write1 = 1'b0;
      write2 = 1'b0;
      if (c < 40 && (c % 2) == 0) begin
        int k;
        k = c / 2;
        if ((k % 2) == 0) begin
          instr1 = {32'hA0000000 | 32'(k), 32'h1000 + 32'(8 * k + 4),
                    32'hB0000000 | 32'(k), 32'h1000 + 32'(8 * k)};
          write1 = 1'b1;
          mq.push_back({1'b1, instr1});
        end else begin
          instr1 = {$urandom, $urandom, 32'hC0000000 | 32'(k), 32'h2000 + 32'(8 * k)};
          instr2 = {$urandom, $urandom, 32'hD0000000 | 32'(k), 32'h2000 + 32'(8 * k + 4)};
          write2 = 1'b1;
          mq.push_back({1'b0, 64'd0, 32'hC0000000 | 32'(k), 32'h2000 + 32'(8 * k)});
          mq.push_back({1'b0, 64'd0, 32'hD0000000 | 32'(k), 32'h2000 + 32'(8 * k + 4)});
        end
      end
      @(negedge clk);
      if (issue_valid) begin
        if (mq.size() == 0) begin
          chk("wrap_pop_when_model_empty", issue_valid, 0);
        end else begin
          exp_b = mq.pop_front();
          chk("wrap_bundle", {issue_dual, issue_data}, exp_b);
          n_pop++;
        end
      end
      tick();
    end
    write1 = 1'b0;
    write2 = 1'b0;
    issue_ready = 1'b0;
    chk("wrap_pop_count", 129'(n_pop), 129'(30));
    chk("wrap_model_left", 129'(mq.size()), 0);
    chk("wrap_ovf", overflow_err, 0);

    // flush collision on a 4-entry queue
    for (int i = 0; i < 4; i++) begin
      instr1 = {64'd0, 32'h44440000 + 32'(i), 32'h600 + 32'(4 * i)};
      write1 = 1'b1;
      tick();
    end
    chk("fl_pre_valid", issue_valid, 1);
    instr1 = {64'd0, 32'h44449999, 32'h6FC};
    flush = 1'b1;
    issue_ready = 1'b1;
    tick();
    flush = 1'b0;
    write1 = 1'b0;
    issue_ready = 1'b0;
    chk("fl_valid", issue_valid, 0);
    chk("fl_data", issue_data, 0);
    chk("fl_ovf", overflow_err, 0);
    chk("fl_stall", fetch_stall, 0);
    instr1 = {64'd0, 32'h55550000, 32'h700};
    write1 = 1'b1;
    tick();
    write1 = 1'b0;
    chk("fl_after_data", issue_data, {64'd0, 32'h55550000, 32'h700});
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    chk("fl_after_empty", issue_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
